// File: rtl/game_pkg.sv
// Shared game-logic types and defaults.
// Damage link FSM states and player hit budget.
package game_pkg;

  typedef enum logic [1:0] {
    ARMED,
    PULSE,
    COOLDOWN,
    DEAD
  } dmg_state_t;

  localparam int DMG_PULSE_CYCLES  = 4;
  localparam int DMG_INVULN_FRAMES = 60;
  localparam int PLAYER_MAX_HITS   = 3;

endpackage

// File: rtl/damage_tx_frame_timer.sv
// Loadable frame down-counter for the invulnerability window.
// Decrements only while nonzero; zero_next flags the final frame.
module frame_timer #(
  parameter int W    = 6,
  parameter int LOAD = 60
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic         dec,
  output logic [W-1:0] cnt_nxt,
  output logic         zero_next
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (load)
      cnt_d = W'(LOAD);
    else if (dec && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  assign cnt_nxt   = cnt_d;
  assign zero_next = dec && !clr && !load
                     && cnt_q == W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/damage_tx.sv
// Damage link transmitter: collision level to rate-limited
// damage pulses, invulnerability window, hit count, game over.
module damage_tx
  import game_pkg::*;
#(
  parameter int PULSE_CYCLES  = DMG_PULSE_CYCLES,
  parameter int INVULN_FRAMES = DMG_INVULN_FRAMES,
  parameter int MAX_HITS      = PLAYER_MAX_HITS,
  parameter int HW            = $clog2(MAX_HITS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          new_frame_in,
  input  logic          hit_in,
  input  logic          clear_in,
  output logic          damage_out,
  output logic          invuln_out,
  output logic          blink_out,
  output logic [HW-1:0] hits_out,
  output logic          game_over_out
);

  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam int FW = $clog2(INVULN_FRAMES + 1);

  dmg_state_t state_q, state_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic [HW-1:0] hits_q, hits_d;
  logic damage_q, damage_d;
  logic invuln_q, invuln_d;
  logic blink_q, blink_d;
  logic over_q, over_d;

  logic          f_load, f_dec, f_zero;
  logic [FW-1:0] f_cnt;
  logic [FW+2:0] f_ext;
  logic          last_pulse, at_max;

  assign last_pulse = pulse_q == PW'(1);
  assign at_max     = hits_q == HW'(MAX_HITS);

  assign f_load = !clear_in && state_q == PULSE
                  && last_pulse && !at_max;
  assign f_dec  = !clear_in && new_frame_in
                  && state_q == COOLDOWN;

  frame_timer #(
    .W    (FW),
    .LOAD (INVULN_FRAMES)
  ) u_frame_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clear_in),
    .load      (f_load),
    .dec       (f_dec),
    .cnt_nxt   (f_cnt),
    .zero_next (f_zero)
  );

  always_comb begin
    state_d = state_q;
    pulse_d = pulse_q;
    hits_d  = hits_q;
    if (clear_in) begin
      state_d = ARMED;
      pulse_d = '0;
      hits_d  = '0;
    end else begin
      unique case (state_q)
        ARMED: begin
          if (hit_in) begin
            state_d = PULSE;
            pulse_d = PW'(PULSE_CYCLES);
            if (!at_max)
              hits_d = hits_q + 1'b1;
          end
        end
        PULSE: begin
          if (pulse_q != '0)
            pulse_d = pulse_q - 1'b1;
          if (last_pulse)
            state_d = at_max ? DEAD : COOLDOWN;
        end
        COOLDOWN: begin
          if (f_zero)
            state_d = ARMED;
        end
        DEAD: ;
        default: state_d = ARMED;
      endcase
    end
  end

  // Outputs follow the next state so they are all flop-driven.
  assign f_ext    = {3'b000, f_cnt};
  assign damage_d = state_d == PULSE;
  assign invuln_d = state_d == PULSE
                    || state_d == COOLDOWN;
  assign blink_d  = state_d == COOLDOWN && f_ext[2];
  assign over_d   = state_d == DEAD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARMED;
      pulse_q  <= '0;
      hits_q   <= '0;
      damage_q <= 1'b0;
      invuln_q <= 1'b0;
      blink_q  <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pulse_q  <= pulse_d;
      hits_q   <= hits_d;
      damage_q <= damage_d;
      invuln_q <= invuln_d;
      blink_q  <= blink_d;
      over_q   <= over_d;
    end
  end

  assign damage_out    = damage_q;
  assign invuln_out    = invuln_q;
  assign blink_out     = blink_q;
  assign hits_out      = hits_q;
  assign game_over_out = over_q;

endmodule
